// File: rtl/itcm_ext_initiator.sv
// Single-command LSU initiator for the external ITCM port (debug/loader path).
// Optional: define ITCM_EXT_INIT_TIMEOUT_EN to abandon unacked requests.
package SOPHON_PKG;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  strb;
  } lsu_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } lsu_ack_t;
endpackage

module itcm_ext_initiator
  import SOPHON_PKG::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_strb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output lsu_req_t    lsu_req_o,
  input  lsu_ack_t    lsu_ack_i
);

  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 4..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  strb_q;
  logic        we_q, err_q, req;
  logic        aligned, accept, timeout;

  assign aligned = (cmd_addr_i[1:0] == 2'b00);
  assign accept  = (state_q == IDLE) && cmd_valid_i;

`ifdef ITCM_EXT_INIT_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counts REQ cycles already elapsed, so it fires in the last allowed one.
  assign timeout = (state_q == REQ) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == REQ) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = aligned ? REQ : RSP;
        end
      end
      REQ: begin
        if (lsu_ack_i.ack || timeout) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    req         = 1'b0;
    unique case (state_q)
      IDLE:    cmd_ready_o = rst_ni;
      REQ:     req         = 1'b1;
      RSP:     rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept && aligned) begin
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
        we_q    <= cmd_we_i;
        strb_q  <= cmd_strb_i;
      end else if (accept) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      // Ack wins over a simultaneous timeout.
      if (state_q == REQ && lsu_ack_i.ack) begin
        rdata_q <= (we_q || lsu_ack_i.error) ? '0 : lsu_ack_i.rdata;
        err_q   <= lsu_ack_i.error;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = err_q;

  assign lsu_req_o = '{
    req:   req,
    addr:  addr_q,
    wdata: wdata_q,
    we:    we_q,
    strb:  strb_q
  };

endmodule

// File: tb/tb_itcm_ext_initiator.sv
// Directed bench for itcm_ext_initiator: vector table plus
// back-to-back, backpressure, reset and timeout sequences.
module tb_itcm_ext_initiator;
  import SOPHON_PKG::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_we;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  lsu_req_t    lsu_req;
  lsu_ack_t    lsu_ack;

  int          checks;
  int          errors;
  int          ack_lat;
  logic        ack_err;
  logic [31:0] ack_rdata;
  int          req_cnt;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          lat;
    logic        aerr;
    logic [31:0] ardata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_req;
  } vec_t;

  itcm_ext_initiator #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_we_i    (cmd_we),
    .cmd_strb_i  (cmd_strb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_error_o (rsp_error),
    .lsu_req_o   (lsu_req),
    .lsu_ack_i   (lsu_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: acks in req cycle ack_lat (0 = never).
  always @(posedge clk) begin
    if (lsu_req.req) req_cnt <= req_cnt + 1;
    else             req_cnt <= 0;
  end

  always_comb begin
    lsu_ack.ack   = lsu_req.req && (ack_lat != 0) &&
                    (req_cnt == ack_lat - 1);
    lsu_ack.error = ack_err;
    lsu_ack.rdata = ack_rdata;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int reqc;
    int wc;
    logic fld_ok;
    ack_lat   = v.lat;
    ack_err   = v.aerr;
    ack_rdata = v.ardata;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_we    = v.we;
    cmd_strb  = v.strb;
    cmd_valid = 1'b1;
    chk($sformatf("v%0d ready_idle", idx), 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reqc   = 0;
    wc     = 0;
    fld_ok = 1'b1;
    while (!rsp_valid && wc < 60) begin
      if (lsu_req.req) begin
        reqc++;
        if (lsu_req.addr !== v.addr || lsu_req.wdata !== v.wdata ||
            lsu_req.we !== v.we || lsu_req.strb !== v.strb)
          fld_ok = 1'b0;
      end
      @(posedge clk); #1;
      wc++;
    end
    chk($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
    chk($sformatf("v%0d rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d error", idx), 32'(rsp_error), 32'(v.exp_err));
    chk($sformatf("v%0d req_cycles", idx), 32'(reqc), 32'(v.exp_req));
    chk($sformatf("v%0d req_fields", idx), 32'(fld_ok), 32'd1);
    chk($sformatf("v%0d req_low_rsp", idx), 32'(lsu_req.req), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk($sformatf("v%0d back_idle", idx), 32'(cmd_ready), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    int acc;
    int rq;
    int gap;
    int min_gap;
    int seen_req;
    logic [31:0] hold_rdata;
    logic        hold_err;
    int wc;

    vecs[0] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3, 1'b0,
                32'h1234_5678, 32'h0, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 3, 1'b0,
                32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[2] = '{1'b0, 32'h0000_0102, 32'h0, 4'h0, 3, 1'b0,
                32'hFFFF_FFFF, 32'h0, 1'b1, 0};
    vecs[3] = '{1'b0, 32'h0000_0204, 32'h0, 4'h0, 1, 1'b1,
                32'h0, 32'h0, 1'b1, 1};
    vecs[4] = '{1'b1, 32'h0000_0001, 32'h1111_2222, 4'h3, 3, 1'b0,
                32'h0, 32'h0, 1'b1, 0};
    vecs[5] = '{1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 5, 1'b0,
                32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 5};

    checks    = 0;
    errors    = 0;
    ack_lat   = 0;
    ack_err   = 1'b0;
    ack_rdata = '0;
    req_cnt   = 0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_we    = 1'b0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst req", 32'(lsu_req.req), 32'd0);
    chk("rst req_addr", lsu_req.addr, 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_error", 32'(rsp_error), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-to-back: cmd_valid and rsp_ready held high.
    ack_lat   = 3;
    ack_err   = 1'b0;
    cmd_addr  = 32'h0000_0040;
    cmd_we    = 1'b0;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    acc = 0; rq = 0; gap = 0; min_gap = 99; seen_req = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) acc++;
      if (cmd_ready && (lsu_req.req || rsp_valid)) begin
        checks++;
        errors++;
        $display("FAIL b2b ready_outside_idle: cycle %0d", i);
      end
      if (lsu_req.req) begin
        if (seen_req != 0 && gap > 0 && gap < min_gap) min_gap = gap;
        seen_req = 1;
        gap = 0;
        rq++;
      end else begin
        gap++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk("b2b accepts", 32'(acc), 32'd2);
    chk("b2b req_cycles", 32'(rq), 32'd6);
    chk("b2b min_low_gap", 32'(min_gap), 32'd2);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("b2b idle", 32'(cmd_ready), 32'd1);

    // Backpressure: response held for 5 cycles.
    ack_lat   = 2;
    ack_rdata = 32'hCAFE_F00D;
    cmd_addr  = 32'h0000_0200;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wc = 0;
    while (!rsp_valid && wc < 20) begin
      @(posedge clk); #1;
      wc++;
    end
    chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
    hold_rdata = rsp_rdata;
    hold_err   = rsp_error;
    chk("bp rdata", hold_rdata, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== hold_rdata ||
          rsp_error !== hold_err || cmd_ready) begin
        errors++;
        $display("FAIL bp hold: cycle %0d valid %b rdata %h ready %b",
                 i, rsp_valid, rsp_rdata, cmd_ready);
      end
      checks++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp idle", 32'(cmd_ready), 32'd1);

    // Reset while in REQ with no ack coming.
    ack_lat   = 0;
    cmd_addr  = 32'h0000_0300;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rst_mid in_req", 32'(lsu_req.req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid req_async", 32'(lsu_req.req), 32'd0);
    chk("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid idle", 32'(cmd_ready), 32'd1);
    chk("rst_mid no_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_mid req_low", 32'(lsu_req.req), 32'd0);

`ifdef ITCM_EXT_INIT_TIMEOUT_EN
    begin
      vec_t tv;
      tv = '{1'b0, 32'h0000_0400, 32'h0, 4'h0, 0, 1'b0,
             32'h7777_7777, 32'h0, 1'b1, 8};
      run_vec(tv, 10);
      tv = '{1'b0, 32'h0000_0400, 32'h0, 4'h0, 8, 1'b0,
             32'h0000_55AA, 32'h0000_55AA, 1'b0, 8};
      run_vec(tv, 11);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
